// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, captures the memory word into a small
// circular FIFO and hands {pc, instr} pairs to decode over valid/ready.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [3:0]  fifo_count
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  LAST    = PTR_W'(DEPTH - 1);
  localparam logic [3:0]        DEPTH_C = 4'(DEPTH);
  localparam logic [31:0]       STEP_C  = 32'(PC_STEP);

  logic [31:0]      pc;
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [3:0]       count;
  logic             full;
  logic             pop;
  logic             push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come from count so head == tail is never ambiguous.
  assign full = (count == DEPTH_C);
  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over any pop this cycle; the head is dropped, not consumed.
      pc    <= {redirect_pc[31:2], 2'b00};
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        pc_q[tail]    <= pc;
        instr_q[tail] <= instr;
        tail          <= ptr_inc(tail);
        pc            <= pc + STEP_C;
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      count <= count + {3'b000, push} - {3'b000, pop};
    end
  end

  assign instr_addr = pc;
  assign out_valid  = (count != 4'd0);
  assign out_instr  = instr_q[head];
  assign out_pc     = pc_q[head];
  assign fifo_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic compared with a
// queue-based model of the fetch FIFO and PC.
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_q[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  // Memory: word at addr is addr ^ K, returned combinationally.
  assign instr = instr_addr ^ K;

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fifo_count(fifo_count)
  );

  // One clock: model follows the behavioural rules using the inputs at the edge.
  task automatic step();
    bit pop, push;
    pop  = (m_q.size() != 0) && out_ready;
    push = fetch_en && !redirect_valid && ((m_q.size() < DEPTH) || pop);
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_pc = 32'h0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, m_pc ^ K});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5550;
    step(); step();
    checks++; if (instr_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp %h", instr_addr, 32'h0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", out_pc); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_free_flow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_pc !== 32'(4 * i) || out_instr !== (32'(4 * i) ^ K))
        begin errors++; $display("FAIL free_pair %0d: got %h/%h exp %h/%h", i, out_pc, out_instr, 32'(4 * i), 32'(4 * i) ^ K); end
      checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL free_count %0d: got %0d exp 1", i, fifo_count); end
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_cnt [5] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (fifo_count !== exp_cnt[i]) begin errors++; $display("FAIL stall_count %0d: got %0d exp %0d", i, fifo_count, exp_cnt[i]); end
      if (i >= 1) begin
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL stall_hold %0d: got %h exp 0", i, out_pc); end
      end
    end
    checks++; if (instr_addr !== 32'h8) begin errors++; $display("FAIL stall_addr: got %h exp 8", instr_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_pc !== 32'(4 * i) || out_valid !== 1'b1)
        begin errors++; $display("FAIL stall_release %0d: got %h v%b exp %h", i, out_pc, out_valid, 32'(4 * i)); end
      step();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    step(); step(); step();
    checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL redir_fill: got %0d exp 2", fifo_count); end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b exp 0", out_valid); end
    checks++; if (instr_addr !== 32'h1000) begin errors++; $display("FAIL redir_addr: got %h exp 1000", instr_addr); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL redir_count: got %0d exp 0", fifo_count); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1000 || out_instr !== (32'h1000 ^ K))
      begin errors++; $display("FAIL redir_first: got v%b %h/%h exp 1000", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_redirect_wrap();
    logic [31:0] exp_pc [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    out_ready = 1'b1; fetch_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_pc !== exp_pc[i] || out_instr !== (exp_pc[i] ^ K))
        begin errors++; $display("FAIL wrap %0d: got %h/%h exp %h", i, out_pc, out_instr, exp_pc[i]); end
    end
  endtask

  task automatic test_fetch_en_drop();
    logic [3:0] exp_cnt [3] = '{4'd1, 4'd0, 4'd0};
    do_reset();
    out_ready = 1'b0;
    step(); step();
    fetch_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (fifo_count !== exp_cnt[i] || instr_addr !== 32'h8)
        begin errors++; $display("FAIL fe_drop %0d: got cnt %0d addr %h exp %0d/8", i, fifo_count, instr_addr, exp_cnt[i]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fe_valid: got %b exp 0", out_valid); end
    fetch_en = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin errors++; $display("FAIL fe_resume: got v%b %h exp 8", out_valid, out_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 15; i++) step();
    out_ready = 1'b0;
    step();
    checks++; if (instr_addr !== 32'h40 || fifo_count !== 4'd2)
      begin errors++; $display("FAIL mid_setup: got %h cnt %0d exp 40/2", instr_addr, fifo_count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || instr_addr !== 32'h0 || fifo_count !== 4'd0)
      begin errors++; $display("FAIL mid_reset: got v%b %h cnt %0d exp 0/0/0", out_valid, instr_addr, fifo_count); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_restart: got v%b %h exp 0", out_valid, out_pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(99) < 75);
      out_ready      = ($urandom_range(99) < 60);
      redirect_valid = ($urandom_range(99) < 6);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(99) < 2);
      step();
      checks++; if (instr_addr !== m_pc) begin errors++; $display("FAIL rnd_addr %0d: got %h exp %h", i, instr_addr, m_pc); end
      checks++; if (fifo_count !== 4'(m_q.size()) || out_valid !== (m_q.size() != 0))
        begin errors++; $display("FAIL rnd_count %0d: got %0d v%b exp %0d", i, fifo_count, out_valid, m_q.size()); end
      if (m_q.size() != 0) begin
        checks++; if ({out_pc, out_instr} !== m_q[0])
          begin errors++; $display("FAIL rnd_head %0d: got %h/%h exp %h", i, out_pc, out_instr, m_q[0]); end
      end
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    m_pc = 32'h0;
    test_reset();
    test_free_flow();
    test_stall();
    test_redirect_full();
    test_redirect_wrap();
    test_fetch_en_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
